// File: rtl/trap_csr_sequencer_if.sv
// Access port of the machine-mode CSR file. The trap/mret sequencer is the master.
// The CSR file is the slave and returns read data.
interface trap_csr_sequencer_if;
   logic [31:0] csr_address_o;
   logic        csr_en_write_o;
   logic        csr_en_read_o;
   logic [31:0] csr_data_o;
   logic        csr_en_except_o;
   logic [31:0] csr_data_i;

   modport master (
      output csr_address_o, csr_en_write_o, csr_en_read_o, csr_data_o, csr_en_except_o,
      input  csr_data_i
   );

   modport slave (
      input  csr_address_o, csr_en_write_o, csr_en_read_o, csr_data_o, csr_en_except_o,
      output csr_data_i
   );
endinterface

// File: rtl/trap_csr_sequencer.sv
// Sequences the CSR accesses for trap entry (mepc, mcause, mstatus, mtvec) and for mret
// (mstatus, mepc), then issues a one-cycle PC redirect.
module trap_csr_sequencer #(
   parameter int unsigned CSR_RD_LAT = 1,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 trap_req_i,
   input  logic [31:0]          trap_cause_i,
   input  logic [31:0]          trap_pc_i,
   input  logic                 mret_req_i,
   output logic                 trap_ack_o,
   output logic                 mret_ack_o,
   output logic                 busy_o,
   output logic                 redirect_valid_o,
   output logic [31:0]          redirect_pc_o,
   trap_csr_sequencer_if.master csr
);
   localparam logic [31:0] ADDR_MSTATUS = 32'h0000_0300;
   localparam logic [31:0] ADDR_MTVEC   = 32'h0000_0305;
   localparam logic [31:0] ADDR_MEPC    = 32'h0000_0341;
   localparam logic [31:0] ADDR_MCAUSE  = 32'h0000_0342;
   localparam logic [1:0]  WAIT_INIT    = 2'(CSR_RD_LAT - 1);

   typedef enum logic [3:0] {
      IDLE, T_WR_EPC, T_WR_CAUSE, T_RD_STATUS, T_WAIT_STATUS, T_WR_STATUS, T_RD_TVEC,
      T_WAIT_TVEC, M_RD_STATUS, M_WAIT_STATUS, M_WR_STATUS, M_RD_EPC, M_WAIT_EPC, REDIRECT
   } state_t;

   state_t      state;
   logic [1:0]  wait_cnt;
   logic [31:0] cause_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        wr_q;
   logic        rd_q;
   logic        busy_q;
   logic        rv_q;
   logic [31:0] rpc_q;

   function automatic logic [31:0] trap_status(input logic [31:0] s);
      logic [31:0] r;
      r        = s;
      r[7]     = s[3];
      r[3]     = 1'b0;
      r[12:11] = 2'b11;
      return r;
   endfunction

   function automatic logic [31:0] mret_status(input logic [31:0] s);
      logic [31:0] r;
      r        = s;
      r[3]     = s[7];
      r[7]     = 1'b1;
      r[12:11] = 2'b11;
      return r;
   endfunction

   // Vectored mode only applies to interrupts; the shifted-out cause bits wrap modulo 2^32.
   function automatic logic [31:0] trap_target(input logic [31:0] tvec, input logic [31:0] cause);
      logic [31:0] base;
      base = tvec & 32'hFFFF_FFFC;
      if (tvec[1:0] == 2'b01 && cause[31]) return base + (cause << 2);
      return base;
   endfunction

   // Acceptance is decoded from the registered IDLE state so the ack shares the sampling cycle.
   assign trap_ack_o = rst_ni && (state == IDLE) && trap_req_i;
   assign mret_ack_o = rst_ni && (state == IDLE) && !trap_req_i && mret_req_i;

   assign busy_o              = busy_q;
   assign redirect_valid_o    = rv_q;
   assign redirect_pc_o       = rpc_q;
   assign csr.csr_address_o   = addr_q;
   assign csr.csr_en_write_o  = wr_q;
   assign csr.csr_en_read_o   = rd_q;
   assign csr.csr_data_o      = wdata_q;
   assign csr.csr_en_except_o = busy_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         wait_cnt <= '0;
         cause_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         busy_q   <= 1'b0;
         rv_q     <= 1'b0;
         rpc_q    <= RESET_PC;
      end else begin
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         rv_q    <= 1'b0;
         busy_q  <= 1'b1;
         case (state)
            IDLE: begin
               if (trap_req_i) begin
                  cause_q <= trap_cause_i;
                  wr_q    <= 1'b1;
                  addr_q  <= ADDR_MEPC;
                  wdata_q <= trap_pc_i & 32'hFFFF_FFFC;
                  state   <= T_WR_EPC;
               end else if (mret_req_i) begin
                  rd_q   <= 1'b1;
                  addr_q <= ADDR_MSTATUS;
                  state  <= M_RD_STATUS;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            T_WR_EPC: begin
               wr_q    <= 1'b1;
               addr_q  <= ADDR_MCAUSE;
               wdata_q <= cause_q;
               state   <= T_WR_CAUSE;
            end
            T_WR_CAUSE: begin
               rd_q   <= 1'b1;
               addr_q <= ADDR_MSTATUS;
               state  <= T_RD_STATUS;
            end
            T_RD_STATUS: begin
               wait_cnt <= WAIT_INIT;
               state    <= T_WAIT_STATUS;
            end
            T_WAIT_STATUS: begin
               if (wait_cnt == 2'd0) begin
                  wr_q    <= 1'b1;
                  addr_q  <= ADDR_MSTATUS;
                  wdata_q <= trap_status(csr.csr_data_i);
                  state   <= T_WR_STATUS;
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            T_WR_STATUS: begin
               rd_q   <= 1'b1;
               addr_q <= ADDR_MTVEC;
               state  <= T_RD_TVEC;
            end
            T_RD_TVEC: begin
               wait_cnt <= WAIT_INIT;
               state    <= T_WAIT_TVEC;
            end
            T_WAIT_TVEC: begin
               if (wait_cnt == 2'd0) begin
                  rpc_q <= trap_target(csr.csr_data_i, cause_q);
                  rv_q  <= 1'b1;
                  state <= REDIRECT;
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            M_RD_STATUS: begin
               wait_cnt <= WAIT_INIT;
               state    <= M_WAIT_STATUS;
            end
            M_WAIT_STATUS: begin
               if (wait_cnt == 2'd0) begin
                  wr_q    <= 1'b1;
                  addr_q  <= ADDR_MSTATUS;
                  wdata_q <= mret_status(csr.csr_data_i);
                  state   <= M_WR_STATUS;
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            M_WR_STATUS: begin
               rd_q   <= 1'b1;
               addr_q <= ADDR_MEPC;
               state  <= M_RD_EPC;
            end
            M_RD_EPC: begin
               wait_cnt <= WAIT_INIT;
               state    <= M_WAIT_EPC;
            end
            M_WAIT_EPC: begin
               if (wait_cnt == 2'd0) begin
                  rpc_q <= csr.csr_data_i & 32'hFFFF_FFFC;
                  rv_q  <= 1'b1;
                  state <= REDIRECT;
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            REDIRECT: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end
endmodule
